// File: rtl/fp32_to_bf16_packer.sv
// fp32 -> bf16 (RNE) converter that packs two results per 32-bit word for writeback.
// Define BF16_SAT_EN to clamp finite overflow to the largest finite bf16 instead of inf.
module fp32_to_bf16_packer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [1:0]       out_keep,
    output logic             out_last,
    output logic [CNT_W-1:0] word_count
);

    logic        sgn;
    logic [7:0]  expo;
    logic        rnd_up;
    logic [14:0] mag_sum;
    logic [15:0] rounded;

    assign sgn     = in_data[31];
    assign expo    = in_data[30:23];
    assign rnd_up  = in_data[15] && ((|in_data[14:0]) || in_data[16]);
    assign mag_sum = in_data[30:16] + {14'h0, rnd_up};

    always_comb begin
        rounded = {sgn, mag_sum};
        if (expo == 8'h00) begin
            rounded = {sgn, 15'h0};
        end else if (expo == 8'hFF) begin
            if (in_data[22:0] != 23'h0)
                rounded = {sgn, 8'hFF, 1'b1, in_data[21:16]};
            else
                rounded = {sgn, 8'hFF, 7'h0};
        end else if (mag_sum[14:7] == 8'hFF) begin
            // A finite input whose rounding carried into the all-ones exponent
`ifdef BF16_SAT_EN
            rounded = {sgn, 15'h7F7F};
`else
            rounded = {sgn, 8'hFF, 7'h0};
`endif
        end
    end

    logic [15:0]      lane0_q, lane0_d;
    logic             lane0_vld_q, lane0_vld_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [1:0]       out_keep_q, out_keep_d;
    logic             out_last_q, out_last_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic             accept, handoff;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid_q && out_ready;

    always_comb begin
        lane0_d      = lane0_q;
        lane0_vld_d  = lane0_vld_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        word_count_d = word_count_q;
        if (handoff) begin
            out_valid_d  = 1'b0;
            word_count_d = word_count_q + CNT_W'(1);
        end
        if (accept) begin
            if (lane0_vld_q) begin
                out_valid_d = 1'b1;
                out_data_d  = {rounded, lane0_q};
                out_keep_d  = 2'b11;
                out_last_d  = in_last;
                lane0_vld_d = 1'b0;
            end else if (in_last) begin
                out_valid_d = 1'b1;
                out_data_d  = {16'h0000, rounded};
                out_keep_d  = 2'b01;
                out_last_d  = 1'b1;
            end else begin
                lane0_d     = rounded;
                lane0_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane0_q      <= '0;
            lane0_vld_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            lane0_q      <= lane0_d;
            lane0_vld_q  <= lane0_vld_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            word_count_q <= word_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_keep   = out_keep_q;
    assign out_last   = out_last_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_fp32_to_bf16_packer.sv
// Bench for fp32_to_bf16_packer: directed cases plus random streams against a word-queue model.
module tb_fp32_to_bf16_packer;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic [1:0]    out_keep;
    logic          out_last;
    logic [CW-1:0] word_count;

    fp32_to_bf16_packer #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  k;
        logic        l;
    } word_t;

    int            n_assert = 0;
    int            n_fail   = 0;
    word_t         exp_q[$];
    logic [15:0]   m_lane;
    bit            m_lane_vld;
    logic [CW-1:0] m_cnt;
    word_t         last_w;
    bit            acc;

    // Reference rounding on the magnitude as an integer: keep the top 15 bits, round half to even.
    function automatic logic [15:0] ref_bf16(input logic [31:0] x);
        int unsigned q, r;
        if (x[30:23] == 8'h00) return {x[31], 15'h0};
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] != 0) return {x[31], 8'hFF, 1'b1, x[21:16]};
            return {x[31], 15'h7F80};
        end
        q = {17'h0, x[30:16]};
        r = {16'h0, x[15:0]};
        if (r > 32768 || (r == 32768 && (q % 2) == 1)) q = q + 1;
        if (q >= 32'h7F80) begin
`ifdef BF16_SAT_EN
            q = 32'h7F7F;
`else
            q = 32'h7F80;
`endif
        end
        return {x[31], q[14:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [31:0] d, input logic l);
        logic [15:0] bf;
        bf = ref_bf16(d);
        if (m_lane_vld) begin
            exp_q.push_back('{d: {bf, m_lane}, k: 2'b11, l: l});
            m_lane_vld = 1'b0;
        end else if (l) begin
            exp_q.push_back('{d: {16'h0000, bf}, k: 2'b01, l: 1'b1});
        end else begin
            m_lane     = bf;
            m_lane_vld = 1'b1;
        end
    endtask

    // One clock: drive, sample at the falling edge, update the model, return just after the rise.
    task automatic cyc(input logic v, input logic [31:0] d, input logic l, input logic r, output bit accepted);
        word_t w;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        @(negedge clk);
        chk("out_valid", {31'h0, out_valid}, {31'h0, exp_q.size() != 0});
        chk("word_count", {{(32-CW){1'b0}}, word_count}, {{(32-CW){1'b0}}, m_cnt});
        accepted = v && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_word", 32'h1, 32'h0);
            end else begin
                w = exp_q.pop_front();
                chk("out_data", out_data, w.d);
                chk("out_keep", {30'h0, out_keep}, {30'h0, w.k});
                chk("out_last", {31'h0, out_last}, {31'h0, w.l});
                m_cnt = m_cnt + 1'b1;
            end
            last_w = '{d: out_data, k: out_keep, l: out_last};
        end
        if (accepted) model_accept(d, l);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        cyc(1'b1, d, l, 1'b1, acc);
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 1'b1, acc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_lane_vld = 1'b0;
        m_lane = '0;
        m_cnt = '0;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_keep", {30'h0, out_keep}, 32'h0);
        chk("rst_out_last", {31'h0, out_last}, 32'h0);
        chk("rst_word_count", {{(32-CW){1'b0}}, word_count}, 32'h0);
    endtask

    initial begin
        logic [31:0] d, hold;
        int guard;
        @(posedge clk);
        do_reset();

        // Pair packing
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        idle();
        chk("pair_data", last_w.d, 32'h40003F80);
        chk("pair_keep", {30'h0, last_w.k}, 32'h3);
        chk("pair_last", {31'h0, last_w.l}, 32'h0);
        chk("pair_count", {{(32-CW){1'b0}}, word_count}, 32'h1);

        // Round-half-even ties
        send(32'h3F808000, 1'b0);
        send(32'h3F818000, 1'b0);
        idle();
        chk("rne_tie", last_w.d, 32'h3F823F80);
        send(32'h3F808001, 1'b0);
        send(32'hBF800000, 1'b0);
        idle();
        chk("rne_sticky", last_w.d, 32'hBF803F81);

        // Special values, each flushed as a half word
        send(32'h7F7FFFFF, 1'b1); idle();
`ifdef BF16_SAT_EN
        chk("sp_overflow", last_w.d, 32'h00007F7F);
`else
        chk("sp_overflow", last_w.d, 32'h00007F80);
`endif
        send(32'h7F800001, 1'b1); idle();
        chk("sp_nan", last_w.d, 32'h00007FC0);
        send(32'hFF800000, 1'b1); idle();
        chk("sp_neg_inf", last_w.d, 32'h0000FF80);
        send(32'h00400000, 1'b1); idle();
        chk("sp_denorm", last_w.d, 32'h00000000);
        send(32'h80000001, 1'b1); idle();
        chk("sp_neg_denorm", last_w.d, 32'h00008000);

        // Flush of an odd-length tile
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b1);
        chk("flush_w0", last_w.d, 32'h40003F80);
        chk("flush_w0_keep", {30'h0, last_w.k}, 32'h3);
        idle();
        chk("flush_w1", last_w.d, 32'h00004040);
        chk("flush_w1_keep", {30'h0, last_w.k}, 32'h1);
        chk("flush_w1_last", {31'h0, last_w.l}, 32'h1);

        // Consecutive last beats
        send(32'h40000000, 1'b1);
        send(32'h40400000, 1'b1);
        idle();
        chk("dbl_last", last_w.d, 32'h00004040);

        // Backpressure: word held stable, no beats accepted
        cyc(1'b1, 32'h3F800000, 1'b0, 1'b0, acc);
        cyc(1'b1, 32'h40000000, 1'b0, 1'b0, acc);
        hold = out_data;
        chk("bp_word", hold, 32'h40003F80);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h40400000, 1'b1, 1'b0, acc);
            chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
            chk("bp_hold", out_data, hold);
        end
        idle();
        idle();

        // Random-stall stream of 16 beats, last one closes the tile
        for (int b = 0; b < 16; b++) begin
            d = $urandom;
            guard = 0;
            do begin
                cyc(($urandom_range(0, 3) != 0), d, (b == 15) || ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 2) != 0), acc);
                guard++;
            end while (!acc && guard < 200);
            if (!acc) chk("stream_timeout", 32'h1, 32'h0);
        end
        repeat (3) idle();
        chk("stream_drained", exp_q.size(), 32'h0);

        // Random rounding sweep with exponent corners
        for (int b = 0; b < 40; b++) begin
            d = $urandom;
            case ($urandom_range(0, 4))
                0: d[30:23] = 8'h00;
                1: d[30:23] = 8'hFF;
                2: begin d[30:23] = 8'hFE; d[22:16] = 7'h7F; end
                3: d[15:0] = 16'h8000;
                default: ;
            endcase
            send(d, (b == 39) || ($urandom_range(0, 3) == 0));
        end
        repeat (2) idle();
        chk("sweep_drained", exp_q.size(), 32'h0);

        // Reset mid-tile
        send(32'h3F800000, 1'b0);
        do_reset();
        idle();
        send(32'h40000000, 1'b0);
        send(32'h3F800000, 1'b0);
        idle();
        chk("rst_first_word", last_w.d, 32'h3F804000);
        chk("rst_count", {{(32-CW){1'b0}}, word_count}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fp32_to_bf16_packer.md
Name: fp32_to_bf16_packer

Overview:
- Output-side drain for the systolic array. It is the reverse of the PE datapath, which takes bf16 operands and produces fp32 accumulations.
- Accepts a valid/ready stream of fp32 results and rounds each one to bf16 using round-to-nearest-even (RNE).
- Packs consecutive bf16 results two per 32-bit word for writeback to the activation buffer.
- One-entry output register; full throughput of one fp32 per cycle when the output is not stalled.

Parameters:
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  fp32 beat present.
- in_ready  out  1  packer accepts the beat this cycle.
- in_data  in  32  IEEE-754 fp32 value.
- in_last  in  1  final element of the tile; forces a flush of a partial word.
- out_valid  out  1  packed word present.
- out_ready  in  1  downstream accepts the word.
- out_data  out  32  [15:0] = earlier bf16, [31:16] = later bf16.
- out_keep  out  2  lane valid mask: 2'b11 for a full word, 2'b01 for a flushed half word.
- out_last  out  1  word contains the tile's last element.
- word_count  out  CNT_W  number of words handed off, wraps modulo 2^CNT_W.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_keep=0, out_last=0, word_count=0. Internal lane0_vld=0.
- Handshake rules:
  - in_ready = !out_valid || out_ready. It is combinational; there is no dependency from in_valid to in_ready.
  - A beat is accepted when in_valid && in_ready.
  - A word is handed off when out_valid && out_ready. word_count increments on each hand-off.
  - out_data, out_keep and out_last are stable while out_valid && !out_ready.
- Rounding (combinational on in_data). Fields: s=[31], e=[30:23], m=[22:0].
  - e==0: the value is zero or denormal and is flushed to signed zero {s,15'h0}, matching the PE's zero handling.
  - e==8'hFF with m!=0 (NaN): output {s,8'hFF,1'b1,m[21:16]}, always a quiet NaN.
  - e==8'hFF with m==0 (inf): pass through as {s,8'hFF,7'h0}.
  - Otherwise apply RNE. lsb=[16], rnd=[15], sticky=|[14:0].
    - Round up when rnd && (sticky || lsb): add 1 to [30:16] using a 15-bit add.
    - A mantissa carry increments the exponent naturally.
    - A result exponent of 8'hFF yields inf {s,8'hFF,7'h0}.
- Packing state: lane0_q[15:0] and lane0_vld.
  - Accept with lane0_vld=0 and in_last=0: lane0_q <= rounded value, lane0_vld <= 1. No output.
  - Accept with lane0_vld=0 and in_last=1: next cycle out_valid=1, out_data={16'h0000, rounded}, out_keep=2'b01, out_last=1. lane0_vld remains 0.
  - Accept with lane0_vld=1: next cycle out_valid=1, out_data={rounded, lane0_q}, out_keep=2'b11, out_last=in_last. lane0_vld <= 0.
  - Latency: one cycle from the accept of the word-completing beat to out_valid.
- Simultaneous events:
  - Hand-off and load in the same cycle: the new word replaces the old one and out_valid stays 1.
  - Hand-off with no load: out_valid <= 0.
- Boundaries:
  - Consecutive in_last beats each produce their own half word.
  - word_count wraps from 2^CNT_W-1 to 0.
  - Reset mid-tile discards lane0 and any pending word. No output is produced in the cycle after reset.

Optional Feature:
- Macro: BF16_SAT_EN.
- Defined: finite inputs whose rounded magnitude overflows to inf saturate to the maximum finite value {s,15'h7F7F}. True inf and NaN inputs are unaffected.
- Undefined: overflow produces inf as described in Behaviour.

Test Plan:
- Pair packing: send 0x3F800000, then 0x40000000 (in_last=0), out_ready=1 -> one word out_data=0x40003F80, keep=2'b11, last=0, word_count=1.
- RNE tie cases: send 0x3F808000 then 0x3F818000 -> out_data=0x3F823F80 (tie with even lsb stays; tie with odd lsb rounds up). Send 0x3F808001 then 0xBF800000 -> out_data=0xBF803F81.
- Special values:
  - 0x7F7FFFFF -> lane 0x7F80 without the macro, 0x7F7F with BF16_SAT_EN.
  - 0x7F800001 -> 0x7FC0.
  - 0xFF800000 -> 0xFF80.
  - 0x00400000 -> 0x0000.
  - 0x80000001 -> 0x8000.
- Flush: three beats 1.0, 2.0, 3.0 (0x40400000) with in_last on the third -> words 0x40003F80 (keep 11, last 0), then 0x00004040 (keep 01, last 1).
- Backpressure: hold out_ready=0 with a word pending -> in_ready=0 and out_data stable for 5 cycles. Raise out_ready -> hand-off with no beats lost or duplicated across a 16-beat random-stall stream.
- Reset: assert rst after a single unpaired beat, then send 0x40000000 + 0x3F800000 -> first word 0x3F804000, word_count restarts at 1.
